// File: rtl/regbank_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regbank_sequencer_pkg
// Description : Shared types and constants for the register-bank sequencer:
//               FSM state encoding, opcode values, error codes, instruction
//               field positions and small decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package regbank_sequencer_pkg;

  // Sequencer states, one per pipeline step of an instruction
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_PCRD   = 4'd1,
    ST_FETCH  = 4'd2,
    ST_DECODE = 4'd3,
    ST_OPRD   = 4'd4,
    ST_EXEC   = 4'd5,
    ST_WB     = 4'd6,
    ST_PCUP   = 4'd7,
    ST_HALT   = 4'd8
  } state_t;

  // Opcodes with a fixed meaning; 0x1-0x7 are ALU functions
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_BEQZ = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Sticky error flags
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // Instruction field positions (imm overlaps rs)
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS_MSB  = 7;
  localparam int RS_LSB  = 4;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  // True for the seven ALU opcodes
  function automatic logic is_alu(input logic [3:0] op);
    return (op != OP_NOP) && !op[3];
  endfunction

  // True for every opcode the sequencer knows how to execute
  function automatic logic is_legal(input logic [3:0] op);
    return (op == OP_NOP) || is_alu(op) || (op == OP_LDI) ||
           (op == OP_BEQZ) || (op == OP_HALT);
  endfunction

  // Branch displacement: sign-extended word offset converted to bytes
  function automatic logic [15:0] branch_offset(input logic [7:0] imm);
    return {{7{imm[7]}}, imm, 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/regbank_fetch_timer.sv
`default_nettype none
// ============================================================================
// Module      : regbank_fetch_timer
// Description : Counts cycles spent waiting for an instruction-fetch ack and
//               flags expiry on the TIMEOUT-th waiting cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module regbank_fetch_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic start,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  // Count waiting cycles; cleared whenever the fetch is not in progress
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (start && !expired) begin
      count <= count + CW'(1);
    end
  end

  // Expiry is signalled during the last allowed waiting cycle
  assign expired = start && (count == CW'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/regbank_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : regbank_sequencer
// Description : Multi-cycle instruction sequencer mastering a 16x16 register
//               bank whose r0 is the PC. Reads PC, fetches over req/ack,
//               reads operands, executes, writes back and commits the PC.
//               wr_en and pc_inc come from distinct states, so they can
//               never be asserted together.
// Revision    : 1.0 - initial release
// ============================================================================
module regbank_sequencer
  import regbank_sequencer_pkg::*;
#(
  parameter int IMEM_TIMEOUT = 15,
  parameter int PC_STEP      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [3:0]  src_reg,
  output logic [3:0]  dst_reg,
  output logic [3:0]  wr_reg,
  output logic [15:0] wr_data,
  output logic        wr_en,
  output logic        pc_inc,
  output logic [15:0] pc_data_in,
  input  logic [15:0] pc_data_out,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [2:0]  alu_op,
  input  logic [15:0] alu_result,
  output logic        busy,
  output logic        halted,
  output logic [1:0]  err
);

  state_t      state, state_nxt;
  logic [15:0] pc_q, ir, res_q;
  logic        branch_taken;
  logic [1:0]  err_q;
  logic        fetch_expired;

  logic [3:0]  op, rd, rs;
  logic [7:0]  imm;

  assign op  = ir[OP_MSB:OP_LSB];
  assign rd  = ir[RD_MSB:RD_LSB];
  assign rs  = ir[RS_MSB:RS_LSB];
  assign imm = ir[IMM_MSB:IMM_LSB];

  // Operand B feeds the ALU directly; the sequencer never inspects it
  logic unused_b;
  assign unused_b = ^b;

  regbank_fetch_timer #(
    .TIMEOUT (IMEM_TIMEOUT)
  ) u_fetch_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state != ST_FETCH),
    .start   (state == ST_FETCH),
    .expired (fetch_expired)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath registers: PC copy, instruction, result, branch flag, errors
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= '0;
      ir           <= '0;
      res_q        <= '0;
      branch_taken <= 1'b0;
      err_q        <= ERR_NONE;
    end else begin
      if (state == ST_PCRD) begin
        pc_q <= pc_data_out;
      end
      if (state == ST_FETCH && imem_ack) begin
        ir <= imem_data;
      end
      if (state == ST_EXEC) begin
        if (op == OP_LDI) begin
          res_q <= {8'h00, imm};
        end else if (is_alu(op)) begin
          res_q <= alu_result;
        end
        branch_taken <= (op == OP_BEQZ) && (a == 16'h0000);
      end
      if (state == ST_FETCH && !imem_ack && fetch_expired) begin
        err_q <= err_q | ERR_TIMEOUT;
      end
      if (state == ST_DECODE && !is_legal(op)) begin
        err_q <= err_q | ERR_ILLEGAL;
      end
      if (state == ST_HALT && run) begin
        err_q <= ERR_NONE;
      end
    end
  end

  // Next-state and per-state output decode
  always_comb begin
    state_nxt  = state;
    imem_req   = 1'b0;
    imem_addr  = '0;
    src_reg    = '0;
    dst_reg    = '0;
    wr_reg     = '0;
    wr_data    = '0;
    wr_en      = 1'b0;
    pc_inc     = 1'b0;
    pc_data_in = '0;
    alu_op     = '0;
    case (state)
      ST_IDLE: begin
        if (run) state_nxt = ST_PCRD;
      end
      ST_PCRD: begin
        state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req  = 1'b1;
        imem_addr = pc_q;
        if (imem_ack)           state_nxt = ST_DECODE;
        else if (fetch_expired) state_nxt = ST_HALT;
      end
      ST_DECODE: begin
        src_reg   = rd;
        dst_reg   = rs;
        state_nxt = is_legal(op) ? ST_OPRD : ST_HALT;
      end
      ST_OPRD: begin
        src_reg   = rd;
        dst_reg   = rs;
        state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        src_reg = rd;
        dst_reg = rs;
        if (is_alu(op)) alu_op = op[2:0];
        if (op == OP_HALT) begin
          state_nxt = ST_HALT;
        end else if ((is_alu(op) || op == OP_LDI) && rd != 4'h0) begin
          state_nxt = ST_WB;
        end else begin
          state_nxt = ST_PCUP;
        end
      end
      ST_WB: begin
        wr_en     = 1'b1;
        wr_reg    = rd;
        wr_data   = res_q;
        state_nxt = ST_PCUP;
      end
      ST_PCUP: begin
        pc_inc     = 1'b1;
        pc_data_in = pc_q + 16'(PC_STEP) +
                     (branch_taken ? branch_offset(imm) : 16'h0000);
        state_nxt  = ST_PCRD;
      end
      ST_HALT: begin
        if (run) state_nxt = ST_PCRD;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign busy   = (state != ST_IDLE) && (state != ST_HALT);
  assign halted = (state == ST_HALT);
  assign err    = err_q;

endmodule
`default_nettype wire
